// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: presents a loaded program one word at a time, each held HOLD_CYCLES cycles.
// Define FETCH_LOOP_EN to replay the program continuously until stop or rst instead of a single pass.
module instr_fetch #(
    parameter int INSTR_WIDTH = 20,
    parameter int DEPTH_BITS  = 5,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [DEPTH_BITS-1:0]  load_addr,
    input  logic [INSTR_WIDTH-1:0] load_instr,
    input  logic [DEPTH_BITS:0]    prog_len,
    input  logic                   start,
    input  logic                   stop,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [DEPTH_BITS-1:0]  pc,
    output logic                   instr_strobe,
    output logic                   busy,
    output logic                   done
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0]          HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [DEPTH_BITS:0] MAX_LEN   = (DEPTH_BITS + 1)'(DEPTH);

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    logic [1:0]             state;
    logic [3:0]             hold_cnt;
    logic [DEPTH_BITS:0]    len;

    logic                   mem_we;
    logic                   start_ok;
    logic                   last_hold;
    logic                   last_pc;
    logic [DEPTH_BITS-1:0]  next_pc;
    logic [INSTR_WIDTH-1:0] first_word;
    logic [DEPTH_BITS:0]    start_len;

    // Memory is writable only while idle, so a run always sees a frozen program.
    assign mem_we    = (state == IDLE) && load_en;
    assign start_ok  = (state == IDLE) && start && (prog_len != '0);
    assign last_hold = (hold_cnt == HOLD_LAST);
    assign last_pc   = ({1'b0, pc} == (len - 1'b1));
    assign next_pc   = pc + 1'b1;
    assign start_len = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;

    // A write to address 0 on the start edge is forwarded so the run opens with the new word.
    assign first_word = (mem_we && (load_addr == '0)) ? load_instr : mem[0];

    // NOTE: program memory has no reset; contents must survive rst and a reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr] <= load_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            len          <= '0;
            pc           <= '0;
            instruction  <= '0;
            instr_strobe <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hold_cnt     <= '0;
                    pc           <= '0;
                    instruction  <= '0;
                    instr_strobe <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    if (start_ok) begin
                        state        <= RUN;
                        len          <= start_len;
                        instruction  <= first_word;
                        instr_strobe <= 1'b1;
                        busy         <= 1'b1;
                    end
                end

                RUN: begin
                    if (stop) begin
                        state        <= IDLE;
                        hold_cnt     <= '0;
                        pc           <= '0;
                        instruction  <= '0;
                        instr_strobe <= 1'b0;
                        busy         <= 1'b0;
                    end else if (last_hold) begin
                        hold_cnt <= '0;
                        if (last_pc) begin
`ifdef FETCH_LOOP_EN
                            pc           <= '0;
                            instruction  <= mem[0];
                            instr_strobe <= 1'b1;
`else
                            state        <= DONE;
                            pc           <= '0;
                            instruction  <= '0;
                            instr_strobe <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
`endif
                        end else begin
                            pc           <= next_pc;
                            instruction  <= mem[next_pc];
                            instr_strobe <= 1'b1;
                        end
                    end else begin
                        hold_cnt     <= hold_cnt + 1'b1;
                        instr_strobe <= 1'b0;
                    end
                end

                DONE: begin
                    state        <= IDLE;
                    hold_cnt     <= '0;
                    pc           <= '0;
                    instruction  <= '0;
                    instr_strobe <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                end

                default: begin
                    state        <= IDLE;
                    hold_cnt     <= '0;
                    pc           <= '0;
                    instruction  <= '0;
                    instr_strobe <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: per-cycle outputs compared against a cycle-indexed program model.
// Compile with +define+FETCH_LOOP_EN to check loop mode instead of single-pass mode.
module tb_instr_fetch;

    localparam int IW    = 20;
    localparam int DB    = 5;
    localparam int H     = 4;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [DB-1:0] pc;
        logic          strobe;
        logic          busy;
        logic          done;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b0;
    logic [DB-1:0] load_addr = '0;
    logic [IW-1:0] load_instr = '0;
    logic [DB:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [IW-1:0] instruction;
    logic [DB-1:0] pc;
    logic          instr_strobe;
    logic          busy;
    logic          done;

    logic [IW-1:0] model_mem [DEPTH];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(.INSTR_WIDTH(IW), .DEPTH_BITS(DB), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_instr(load_instr), .prog_len(prog_len), .start(start), .stop(stop),
        .instruction(instruction), .pc(pc), .instr_strobe(instr_strobe),
        .busy(busy), .done(done)
    );

    // Expected outputs k cycles after an accepted start of an L-word program.
    function automatic obs_t expect_at(input int k, input int len, input int abort_k);
        obs_t e;
        int   p;
        e = '0;
        if (len == 0) return e;
        if (abort_k >= 0 && k > abort_k) return e;
`ifdef FETCH_LOOP_EN
        p        = (k / H) % len;
        e.pc     = p[DB-1:0];
        e.instr  = model_mem[p];
        e.strobe = (k % H == 0);
        e.busy   = 1'b1;
`else
        if (k < len * H) begin
            p        = k / H;
            e.pc     = p[DB-1:0];
            e.instr  = model_mem[p];
            e.strobe = (k % H == 0);
            e.busy   = 1'b1;
        end else if (k == len * H) begin
            e.done = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic compare(input string name, input int k, input obs_t exp);
        obs_t got;
        got = {instruction, pc, instr_strobe, busy, done};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got instr=%h pc=%0d stb=%b busy=%b done=%b expected instr=%h pc=%0d stb=%b busy=%b done=%b",
                     name, k, got.instr, got.pc, got.strobe, got.busy, got.done,
                     exp.instr, exp.pc, exp.strobe, exp.busy, exp.done);
        end
    endtask

    task automatic load_word(input int addr, input logic [IW-1:0] data);
        @(negedge clk);
        load_en    = 1'b1;
        load_addr  = addr[DB-1:0];
        load_instr = data;
        @(negedge clk);
        load_en = 1'b0;
        model_mem[addr] = data;
    endtask

    // Start a run, compare n_obs cycles, optionally abort (stop or rst) after cycle abort_k,
    // optionally inject start+load_en after cycle inj_k, then stop and confirm idle.
    task automatic do_run(input string name, input int plen, input int n_obs, input int abort_k,
                          input bit use_rst, input int inj_k, input bit same_load,
                          input logic [IW-1:0] same_data);
        int len;
        len = (plen > DEPTH) ? DEPTH : plen;
        @(negedge clk);
        start    = 1'b1;
        prog_len = plen[DB:0];
        if (same_load) begin
            load_en      = 1'b1;
            load_addr    = '0;
            load_instr   = same_data;
            model_mem[0] = same_data;
        end
        for (int k = 0; k < n_obs; k++) begin
            @(negedge clk);
            compare(name, k, expect_at(k, len, abort_k));
            start   = 1'b0;
            load_en = 1'b0;
            stop    = 1'b0;
            rst     = 1'b0;
            if (k == inj_k) begin
                start      = 1'b1;
                prog_len   = 6'd1;
                load_en    = 1'b1;
                load_addr  = '0;
                load_instr = ~model_mem[0];
            end
            if (k == abort_k) begin
                if (use_rst) rst = 1'b1;
                else         stop = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0; load_en = 1'b0; rst = 1'b0; stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        compare({name, "_idle"}, n_obs + 1, '0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        compare("reset", 0, '0);
        @(negedge clk);
        compare("reset_hold", 1, '0);
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int a = 0; a < DEPTH; a++) load_word(a, IW'($urandom));
    endtask

    task automatic test_basic_run();
        load_word(0, 20'h47000);
        load_word(1, 20'h53000);
        load_word(2, 20'h72001);
        do_run("basic", 3, 15, -1, 1'b0, -1, 1'b0, '0);
    endtask

    task automatic test_abort();
        do_run("abort", 3, 12, H + 1, 1'b0, -1, 1'b0, '0);
    endtask

    task automatic test_reset_mid_run();
        do_run("rst_mid", 3, 12, 2 * H, 1'b1, -1, 1'b0, '0);
        do_run("restart", 1, H + 2, -1, 1'b0, -1, 1'b0, '0);
        checks++;
        if (model_mem[0] !== 20'h47000) begin
            errors++;
            $display("FAIL restart_word model=%h expected=%h", model_mem[0], 20'h47000);
        end
    endtask

    task automatic test_zero_len();
        do_run("zero_len", 0, 6, -1, 1'b0, -1, 1'b0, '0);
    endtask

    task automatic test_ignore_in_run();
        do_run("ignore", 3, 14, 2, 1'b0, 2, 1'b0, '0);
        do_run("ignore", 3, 14, -1, 1'b0, 5, 1'b0, '0);
        do_run("mem_kept", 1, H + 2, -1, 1'b0, -1, 1'b0, '0);
    endtask

    task automatic test_full_len();
        do_run("len40", 40, DEPTH * H + 2, -1, 1'b0, -1, 1'b0, '0);
        do_run("len32", 32, DEPTH * H + 2, -1, 1'b0, -1, 1'b0, '0);
    endtask

    task automatic test_same_cycle_load();
        do_run("same_load", 2, 2 * H + 2, -1, 1'b0, -1, 1'b1, 20'hDC0F0);
        checks++;
        if (model_mem[0] !== 20'hDC0F0) begin
            errors++;
            $display("FAIL same_load_word model=%h expected=%h", model_mem[0], 20'hDC0F0);
        end
    endtask

`ifdef FETCH_LOOP_EN
    task automatic test_loop();
        do_run("loop", 2, 10 * H, -1, 1'b0, -1, 1'b0, '0);
        do_run("loop_stop", 3, 20, 17, 1'b0, -1, 1'b0, '0);
    endtask
`endif

    task automatic test_random();
        int plen, len, n_obs, abort_k, inj_k;
        bit use_rst;
        for (int r = 0; r < 10; r++) begin
            for (int w = 0; w < 3; w++) load_word($urandom_range(0, DEPTH - 1), IW'($urandom));
            plen    = $urandom_range(0, 40);
            len     = (plen > DEPTH) ? DEPTH : plen;
            n_obs   = len * H + 2 + $urandom_range(0, 3);
            abort_k = -1;
            inj_k   = -1;
            use_rst = $urandom_range(0, 1) == 1;
            if (len > 0 && $urandom_range(0, 1) == 1) abort_k = $urandom_range(0, len * H - 1);
            if (len > 0 && $urandom_range(0, 1) == 1) inj_k = $urandom_range(0, len * H - 1);
            if (abort_k >= 0 && inj_k > abort_k) inj_k = -1;
            do_run("random", plen, n_obs, abort_k, use_rst, inj_k, 1'b0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic_run();
        test_abort();
        test_reset_mid_run();
        test_zero_len();
        test_ignore_in_run();
        test_full_len();
        test_same_cycle_load();
`ifdef FETCH_LOOP_EN
        test_loop();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
